// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// instruction width, the NOP encoding and small PC helpers.
package inst_fetch_pkg;

    localparam int INST_W = 32;

    // addi x0, x0, 0 -- presented by flushed buffer slots so a stray
    // sample of inst_o after a redirect decodes as harmless.
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10
    } fetch_state_e;

    // Next sequential word address, wrapping modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_buf.sv
// Instruction buffer: small synchronous FIFO of {instruction, pc} pairs
// with occupancy count, flush, and simultaneous push/pop (also when full).
module inst_buf
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [INST_W-1:0] i_push_inst,
    input  logic [31:0]       i_push_pc,
    input  logic              i_pop,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count,
    output logic [INST_W-1:0] o_head_inst,
    output logic [31:0]       o_head_pc
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [INST_W-1:0] r_inst_mem [DEPTH];
    logic [31:0]       r_pc_mem   [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_LAST) begin
            n = '0;
        end else begin
            n = p + PTR_ONE;
        end
        return n;
    endfunction

    // Qualify push/pop: a pop frees the slot a same-cycle push needs.
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == CNT_FULL);
        w_do_pop  = i_pop && !w_empty;
        w_do_push = i_push && (!w_full || w_do_pop);
    end

    // Read/write pointers and occupancy count; flush empties the FIFO.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; reset clears it so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_mem[i] <= '0;
                r_pc_mem[i]   <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_mem[i] <= NOP_INST;
            end
        end else if (w_do_push) begin
            r_inst_mem[r_wr_ptr] <= i_push_inst;
            r_pc_mem[r_wr_ptr]   <= i_push_pc;
        end
    end

    // Head is read straight out of registered storage.
    always_comb begin
        o_empty     = w_empty;
        o_count     = r_count;
        o_head_inst = r_inst_mem[r_rd_ptr];
        o_head_pc   = r_pc_mem[r_rd_ptr];
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues in-order word requests to instruction
// memory, tags responses with their PC, buffers them for the decoder and
// discards responses that belong to a stream abandoned by a redirect.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IBUF_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic              imem_req_o,
    output logic [31:0]       imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       return_pc_o
);

    localparam int CNT_W = $clog2(IBUF_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'(IBUF_DEPTH);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [31:0]       r_fetch_pc;
    logic [31:0]       w_fetch_pc_nxt;
    // PC of the next response that will be kept. Responses return in
    // request order, so this replaces a PC queue.
    logic [31:0]       r_resp_pc;
    logic [31:0]       w_resp_pc_nxt;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  w_outstanding_nxt;
    logic [CNT_W-1:0]  r_discard;
    logic [CNT_W-1:0]  w_discard_nxt;

    logic              w_active;
    logic [SUM_W-1:0]  w_inflight;
    logic              w_req;
    logic              w_hs;
    logic              w_rsp;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;

    logic [CNT_W-1:0]  w_buf_count;
    logic              w_buf_empty;
    logic [INST_W-1:0] w_head_inst;
    logic [31:0]       w_head_pc;

    // Request gating and per-cycle handshake/response/pop events.
    always_comb begin
        case (r_state)
            ST_FETCH: w_active = 1'b1;
            ST_DRAIN: w_active = 1'b1;
            default:  w_active = 1'b0;
        endcase
        w_inflight = {1'b0, r_outstanding} + {1'b0, w_buf_count};
        w_req      = w_active && !redirect_i && (w_inflight < SUM_MAX);
        w_hs       = w_req && imem_gnt_i;
        // Ignore a response with nothing outstanding so counters never underflow.
        w_rsp      = imem_rvalid_i && (r_outstanding != '0);
        w_drop     = w_rsp && (r_discard != '0);
        w_push     = w_rsp && (r_discard == '0) && !redirect_i;
        w_pop      = !w_buf_empty && inst_ready_i && !redirect_i;
    end

    // Next-state, PC and counter logic; redirect overrides everything else.
    always_comb begin
        w_state_nxt       = r_state;
        w_fetch_pc_nxt    = r_fetch_pc;
        w_resp_pc_nxt     = r_resp_pc;
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;

        case ({w_hs, w_rsp})
            2'b10:   w_outstanding_nxt = r_outstanding + CNT_ONE;
            2'b01:   w_outstanding_nxt = r_outstanding - CNT_ONE;
            default: w_outstanding_nxt = r_outstanding;
        endcase

        if (redirect_i) begin
            // No handshake is possible this cycle, so everything still in
            // flight after this cycle's response belongs to the old stream.
            w_fetch_pc_nxt = word_align(redirect_pc_i);
            w_resp_pc_nxt  = word_align(redirect_pc_i);
            w_discard_nxt  = w_outstanding_nxt;
            if (w_outstanding_nxt != '0) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_FETCH;
            end
        end else begin
            if (w_hs) begin
                w_fetch_pc_nxt = pc_inc(r_fetch_pc);
            end else begin
                w_fetch_pc_nxt = r_fetch_pc;
            end
            if (w_push) begin
                w_resp_pc_nxt = pc_inc(r_resp_pc);
            end else begin
                w_resp_pc_nxt = r_resp_pc;
            end
            if (w_drop) begin
                w_discard_nxt = r_discard - CNT_ONE;
            end else begin
                w_discard_nxt = r_discard;
            end
            case (r_state)
                ST_BOOT:  w_state_nxt = ST_FETCH;
                ST_FETCH: w_state_nxt = ST_FETCH;
                ST_DRAIN: begin
                    if (w_discard_nxt == '0) begin
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end
                default:  w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch/response PCs and the outstanding/discard counters.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_nxt;
            r_resp_pc     <= w_resp_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    inst_buf #(
        .DEPTH (IBUF_DEPTH)
    ) u_inst_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_flush     (redirect_i),
        .i_push      (w_push),
        .i_push_inst (imem_rdata_i),
        .i_push_pc   (r_resp_pc),
        .i_pop       (w_pop),
        .o_empty     (w_buf_empty),
        .o_count     (w_buf_count),
        .o_head_inst (w_head_inst),
        .o_head_pc   (w_head_pc)
    );

    // Drive the memory and decoder interfaces.
    always_comb begin
        imem_req_o   = w_req;
        imem_addr_o  = r_fetch_pc;
        inst_valid_o = !w_buf_empty;
        inst_o       = w_head_inst;
        pc_o         = w_head_pc;
        return_pc_o  = pc_inc(w_head_pc);
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a queue-based in-order memory model,
// plus a direct check of the buffer's push-and-pop-while-full behaviour.
module tb_inst_fetch;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] return_pc_o;

    logic        b_flush;
    logic        b_push;
    logic [31:0] b_push_inst;
    logic [31:0] b_push_pc;
    logic        b_pop;
    logic        b_empty;
    logic [1:0]  b_count;
    logic [31:0] b_head_inst;
    logic [31:0] b_head_pc;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] pend_q[$];
    logic [31:0] gnt_q[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_inst_q[$];
    logic [31:0] pop_ret_q[$];
    bit          rsp_hold;

    always #5 clk_i = ~clk_i;

    inst_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IBUF_DEPTH (2)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .return_pc_o   (return_pc_o)
    );

    inst_buf #(
        .DEPTH (2)
    ) u_buf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .i_flush     (b_flush),
        .i_push      (b_push),
        .i_push_inst (b_push_inst),
        .i_push_pc   (b_push_pc),
        .i_pop       (b_pop),
        .o_empty     (b_empty),
        .o_count     (b_count),
        .o_head_inst (b_head_inst),
        .o_head_pc   (b_head_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) begin
            return q[i];
        end else begin
            return 32'hDEAD_BEEF;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: log grants/pops, then present the next in-order response.
    task automatic step();
        #1;
        if (imem_req_o && imem_gnt_i) begin
            pend_q.push_back(imem_addr_o);
            gnt_q.push_back(imem_addr_o);
        end
        if (inst_valid_o && inst_ready_i && !redirect_i) begin
            pop_pc_q.push_back(pc_o);
            pop_inst_q.push_back(inst_o);
            pop_ret_q.push_back(return_pc_o);
        end
        @(posedge clk_i);
        #1;
        if (!rsp_hold && pend_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        reset_i       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = 1'b0;
        rsp_hold      = 1'b0;
        pend_q.delete();
        gnt_q.delete();
        pop_pc_q.delete();
        pop_inst_q.delete();
        pop_ret_q.delete();
        repeat (2) @(negedge clk_i);
    endtask

    task automatic buf_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        b_flush = 1'b0; b_push = 1'b0; b_push_inst = 32'h0; b_push_pc = 32'h0; b_pop = 1'b0;

        // Reset values
        do_reset();
        chk("rst_req",   {31'd0, imem_req_o},   32'd0);
        chk("rst_addr",  imem_addr_o,           32'h0000_0000);
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst",  inst_o,                32'h0);
        chk("rst_pc",    pc_o,                  32'h0);
        chk("rst_ret",   return_pc_o,           32'h4);

        // A: streaming, gnt=1, ready=1
        imem_gnt_i = 1'b1; inst_ready_i = 1'b1; reset_i = 1'b1;
        #1 chk("A_boot_req", {31'd0, imem_req_o}, 32'd0);
        step();
        chk("A_c2_req",  {31'd0, imem_req_o}, 32'd1);
        chk("A_c2_addr", imem_addr_o, 32'h0);
        step();
        chk("A_c3_req",  {31'd0, imem_req_o}, 32'd1);
        chk("A_c3_addr", imem_addr_o, 32'h4);
        step();
        chk("A_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("A_pc",    pc_o,        32'h0);
        chk("A_ret",   return_pc_o, 32'h4);
        chk("A_inst",  inst_o,      mem_word(32'h0));
        chk("A_full_req", {31'd0, imem_req_o}, 32'd0);
        repeat (8) step();
        chk("A_gnt0", q_at(gnt_q, 0), 32'h0);
        chk("A_gnt1", q_at(gnt_q, 1), 32'h4);
        chk("A_gnt2", q_at(gnt_q, 2), 32'h8);
        chk("A_pop1", q_at(pop_pc_q, 1), 32'h4);
        chk("A_pop2", q_at(pop_pc_q, 2), 32'h8);
        chk("A_pop2_inst", q_at(pop_inst_q, 2), mem_word(32'h8));

        // B: decoder stalled, reset taken mid-stream first
        do_reset();
        chk("B_rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("B_rst_req",   {31'd0, imem_req_o},   32'd0);
        imem_gnt_i = 1'b1; inst_ready_i = 1'b0; reset_i = 1'b1;
        step();
        repeat (6) step();
        chk("B_grants", gnt_q.size(), 32'd2);
        chk("B_req",    {31'd0, imem_req_o},   32'd0);
        chk("B_valid",  {31'd0, inst_valid_o}, 32'd1);
        chk("B_head",   pc_o, 32'h0);
        inst_ready_i = 1'b1;
        repeat (6) step();
        chk("B_pop0",   q_at(pop_pc_q, 0), 32'h0);
        chk("B_pop1",   q_at(pop_pc_q, 1), 32'h4);
        chk("B_resume", q_at(gnt_q, 2),    32'h8);

        // C: grant withheld for 5 cycles
        do_reset();
        imem_gnt_i = 1'b0; inst_ready_i = 1'b1; reset_i = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("C_req",  {31'd0, imem_req_o}, 32'd1);
            chk("C_addr", imem_addr_o, 32'h0);
            step();
        end
        chk("C_nogrant", gnt_q.size(), 32'd0);
        imem_gnt_i = 1'b1;
        step();
        chk("C_grant", gnt_q.size(), 32'd1);
        chk("C_adv",   imem_addr_o, 32'h4);

        // D: redirect with two responses outstanding
        do_reset();
        imem_gnt_i = 1'b1; inst_ready_i = 1'b1; rsp_hold = 1'b1; reset_i = 1'b1;
        step();
        step();
        step();
        chk("D_out2_req", {31'd0, imem_req_o}, 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        step();
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        chk("D_addr",  imem_addr_o, 32'h100);
        chk("D_valid", {31'd0, inst_valid_o}, 32'd0);
        rsp_hold = 1'b0;
        repeat (8) step();
        chk("D_gnt_new",  q_at(gnt_q, 2),      32'h100);
        chk("D_gnt_next", q_at(gnt_q, 3),      32'h104);
        chk("D_pop0",     q_at(pop_pc_q, 0),   32'h100);
        chk("D_pop0_inst", q_at(pop_inst_q, 0), mem_word(32'h100));
        chk("D_pop1",     q_at(pop_pc_q, 1),   32'h104);

        // E: fetch PC wraps past 0xFFFF_FFFC
        do_reset();
        imem_gnt_i = 1'b1; inst_ready_i = 1'b1; reset_i = 1'b1;
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        step();
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        chk("E_addr", imem_addr_o, 32'hFFFF_FFFC);
        step();
        chk("E_wrap_addr", imem_addr_o, 32'h0);
        repeat (6) step();
        chk("E_pop0",      q_at(pop_pc_q, 0),   32'hFFFF_FFFC);
        chk("E_pop0_ret",  q_at(pop_ret_q, 0),  32'h0);
        chk("E_pop0_inst", q_at(pop_inst_q, 0), mem_word(32'hFFFF_FFFC));
        chk("E_pop1",      q_at(pop_pc_q, 1),   32'h0);

        // F: buffer push+pop while full
        b_push = 1'b1; b_push_inst = 32'hAAAA_0001; b_push_pc = 32'h10;
        buf_step();
        b_push_inst = 32'hAAAA_0002; b_push_pc = 32'h14;
        buf_step();
        b_push = 1'b0;
        chk("F_full_cnt",  {30'd0, b_count}, 32'd2);
        chk("F_head0",     b_head_pc, 32'h10);
        b_push = 1'b1; b_push_inst = 32'hAAAA_0003; b_push_pc = 32'h18; b_pop = 1'b1;
        buf_step();
        b_push = 1'b0;
        chk("F_pp_cnt",    {30'd0, b_count}, 32'd2);
        chk("F_pp_head",   b_head_pc,   32'h14);
        chk("F_pp_inst",   b_head_inst, 32'hAAAA_0002);
        buf_step();
        b_pop = 1'b0;
        chk("F_pop_cnt",   {30'd0, b_count}, 32'd1);
        chk("F_pop_head",  b_head_pc,   32'h18);
        chk("F_pop_inst",  b_head_inst, 32'hAAAA_0003);
        b_flush = 1'b1;
        buf_step();
        b_flush = 1'b0;
        chk("F_flush_empty", {31'd0, b_empty}, 32'd1);
        chk("F_flush_cnt",   {30'd0, b_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
